// File: rtl/serial2tcp_pkg.sv
// Shared types for the serial2tcp loopback: byte type and stream width.
package serial2tcp_pkg;

  localparam int DATA_W = 8;

  typedef logic [DATA_W-1:0] byte_t;

endpackage

// File: rtl/serial2tcp_sync_fifo.sv
// Generic single-clock FIFO. Read data comes straight from storage (0 when empty).
// A write is ignored when full and a read is ignored when empty.
module serial2tcp_sync_fifo
  import serial2tcp_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign push  = wr_en & ~full;
  assign pop   = rd_en & ~empty;

  // Storage is deliberately left out of reset; empty masks stale contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/serial2tcp_loopback.sv
// Echoes every source byte back on the sink stream through a DEPTH-byte FIFO.
// Accepted byte is visible on the sink the cycle after the push; source_ready drops only when full.
module serial2tcp_loopback
  import serial2tcp_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic        sys_clk,
  input  logic        serial2tcp_source_valid,
  output logic        serial2tcp_source_ready,
  input  logic [7:0]  serial2tcp_source_data,
  output logic        serial2tcp_sink_valid,
  input  logic        serial2tcp_sink_ready,
  output logic [7:0]  serial2tcp_sink_data,
  input  logic        sys_rst_n
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]    rst_sync;
  logic          core_rst_n;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  byte_t         fifo_rd_data;

  // Assertion is immediate; release is aligned to sys_clk after two flops.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign core_rst_n = rst_sync[1];

  serial2tcp_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (sys_clk),
    .rst_n   (core_rst_n),
    .wr_en   (serial2tcp_source_valid & ~fifo_full),
    .wr_data (serial2tcp_source_data),
    .full    (fifo_full),
    .rd_en   (serial2tcp_sink_ready & ~fifo_empty),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign serial2tcp_source_ready = (fifo_count != CW'(DEPTH));
  assign serial2tcp_sink_valid   = (fifo_count != '0);
  assign serial2tcp_sink_data    = fifo_rd_data;

endmodule

// File: tb/tb_serial2tcp_loopback.sv
// Directed and randomized checks of the serial2tcp byte loopback.
module tb_serial2tcp_loopback;

  localparam int DEPTH = 16;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       source_valid;
  logic       source_ready;
  logic [7:0] source_data;
  logic       sink_valid;
  logic       sink_ready;
  logic [7:0] sink_data;

  int n_vec = 0;
  int n_err = 0;

  serial2tcp_loopback #(.DEPTH(DEPTH)) dut (
    .sys_clk                 (sys_clk),
    .serial2tcp_source_valid (source_valid),
    .serial2tcp_source_ready (source_ready),
    .serial2tcp_source_data  (source_data),
    .serial2tcp_sink_valid   (sink_valid),
    .serial2tcp_sink_ready   (sink_ready),
    .serial2tcp_sink_data    (sink_data),
    .sys_rst_n               (sys_rst_n)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    logic [7:0] exp_b;
    logic [7:0] prev_dat;
    logic       prev_hold;
    int         pushed;
    int         popped;
    int         cycles;
    int         occ;

    source_valid = 1'b0;
    source_data  = 8'h00;
    sink_ready   = 1'b0;
    sys_rst_n    = 1'b0;

    // Reset state
    repeat (3) @(negedge sys_clk);
    chk("rst_src_rdy", source_ready, 1);
    chk("rst_snk_vld", sink_valid, 0);
    chk("rst_snk_dat", sink_data, 8'h00);
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("idle_snk_vld", sink_valid, 0);

    // Single byte with sink_ready held high
    source_valid = 1'b1;
    source_data  = 8'hA5;
    sink_ready   = 1'b1;
    @(negedge sys_clk);
    source_valid = 1'b0;
    chk("single_vld", sink_valid, 1);
    chk("single_dat", sink_data, 8'hA5);
    @(negedge sys_clk);
    chk("single_empty", sink_valid, 0);

    // Fill to DEPTH with sink stalled
    sink_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      chk("fill_rdy", source_ready, 1);
      source_valid = 1'b1;
      source_data  = 8'(i);
      @(negedge sys_clk);
    end
    chk("fill_full", source_ready, 0);
    chk("fill_vld", sink_valid, 1);
    source_data = 8'h10;
    @(negedge sys_clk);
    chk("offer17_rdy", source_ready, 0);
    chk("offer17_head", sink_data, 8'h00);

    // Full with push offered and pop together: only the pop happens
    sink_ready = 1'b1;
    @(negedge sys_clk);
    chk("fullpop_rdy", source_ready, 1);
    chk("fullpop_head", sink_data, 8'h01);
    sink_ready = 1'b0;
    @(negedge sys_clk);
    source_valid = 1'b0;
    chk("refill_full", source_ready, 0);
    sink_ready = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      chk("drain_vld", sink_valid, 1);
      chk("drain_dat", sink_data, 32'(i));
      @(negedge sys_clk);
    end
    chk("drain_empty", sink_valid, 0);
    sink_ready = 1'b0;

    // Random streaming against a queue model
    pushed    = 0;
    popped    = 0;
    cycles    = 0;
    prev_hold = 1'b0;
    prev_dat  = 8'h00;
    while (popped < 256 && cycles < 5000) begin
      source_valid = (pushed < 256) && ($urandom_range(0, 1) == 1);
      source_data  = 8'($urandom_range(0, 255));
      sink_ready   = ($urandom_range(0, 1) == 1);
      #1;
      occ = q.size();
      if (prev_hold) begin
        chk("stall_vld", sink_valid, 1);
        chk("stall_dat", sink_data, prev_dat);
      end
      chk("occ_src_rdy", source_ready, (occ != DEPTH) ? 1 : 0);
      chk("occ_snk_vld", sink_valid, (occ != 0) ? 1 : 0);
      if (sink_ready && occ != 0) begin
        exp_b = q.pop_front();
        chk("stream_dat", sink_data, exp_b);
        popped++;
      end
      if (source_valid && occ != DEPTH) begin
        q.push_back(source_data);
        pushed++;
      end
      prev_hold = sink_valid && !sink_ready;
      prev_dat  = sink_data;
      @(negedge sys_clk);
      cycles++;
    end
    chk("stream_done", popped, 256);
    source_valid = 1'b0;
    sink_ready   = 1'b0;
    @(negedge sys_clk);

    // Mid-stream asynchronous reset
    for (int i = 0; i < 5; i++) begin
      source_valid = 1'b1;
      source_data  = 8'h50 + 8'(i);
      @(negedge sys_clk);
    end
    source_valid = 1'b0;
    chk("mr_pre_vld", sink_valid, 1);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("mr_vld", sink_valid, 0);
    chk("mr_rdy", source_ready, 1);
    chk("mr_dat", sink_data, 8'h00);
    @(negedge sys_clk);
    #2 sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("mr_post_vld", sink_valid, 0);
    source_valid = 1'b1;
    source_data  = 8'h3C;
    @(negedge sys_clk);
    source_valid = 1'b0;
    chk("mr_new_vld", sink_valid, 1);
    chk("mr_new_dat", sink_data, 8'h3C);
    sink_ready = 1'b1;
    @(negedge sys_clk);
    chk("mr_new_empty", sink_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
